// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues one outstanding word read at a time and
// hands {instruction, pc} to decode. Handles redirects, stale responses and timeouts.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  output logic        misalign_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, OUT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] ipc_q, ipc_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        ferr_q, ferr_nxt;
  logic        merr_q, merr_nxt;

  logic        cnt_done;
  logic [7:0]  cnt_inc;
  logic [31:0] redir_target;

  // The counter saturates so a long DRAIN can never wrap back below the limit.
  assign cnt_done     = (cnt >= CNT_LAST);
  assign cnt_inc      = cnt_done ? cnt : cnt + 8'd1;
  assign redir_target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt     <= '0;
      ferr_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_nxt;
      ipc_q   <= ipc_nxt;
      cnt     <= cnt_nxt;
      ferr_q  <= ferr_nxt;
      merr_q  <= merr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    ipc_nxt   = ipc_q;
    cnt_nxt   = cnt;
    ferr_nxt  = 1'b0;
    merr_nxt  = redirect_valid && (redirect_pc[1:0] != 2'b00);

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_nxt = redirect_valid ? DRAIN : WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        cnt_nxt = cnt_inc;
        if (redirect_valid) begin
          state_nxt = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          instr_nxt = imem_rsp_data;
          ipc_nxt   = pc;
          state_nxt = OUT;
        end else if (cnt_done) begin
          ferr_nxt  = 1'b1;
          state_nxt = REQ;
        end
      end
      // A squashed request still owes one response; swallow it before reissuing.
      DRAIN: begin
        cnt_nxt = cnt_inc;
        if (!redirect_valid && (imem_rsp_valid || cnt_done)) state_nxt = REQ;
      end
      OUT: begin
        if (redirect_valid) begin
          state_nxt = REQ;
        end else if (if_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (redirect_valid) pc_nxt = redir_target;
  end

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = (state == REQ) ? pc : '0;
  assign if_valid       = (state == OUT);
  assign if_instr       = instr_q;
  assign if_pc          = ipc_q;
  assign fetch_err      = ferr_q;
  assign misalign_err   = merr_q;

endmodule
